// File: rtl/safecrack_pkg.sv
// safecrack_pkg: shared state encoding and thermometer helper for the combination-lock controller
package safecrack_pkg;

    typedef enum logic [3:0] {
        ENTER = 4'b0001,
        OPEN  = 4'b0010,
        PROG  = 4'b0100,
        LOCK  = 4'b1000
    } state_t;

    // Bit i is set for every i < n, capped at width; callers cast to their LED width.
    function automatic logic [31:0] thermo(input int n, input int width);
        logic [31:0] t;
        t = '0;
        for (int i = 0; i < 32; i++) t[i] = (i < n) && (i < width);
        return t;
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// sec_tick_gen: seconds prescaler producing a one-cycle tick every TICKS_PER_SEC enabled cycles
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] cnt_q;

    assign tick = en && (cnt_q == C_LAST);

    // Count while enabled, restart at the wrap and whenever disabled
    always_ff @(posedge clk) begin
        cnt_q <= (rst || !en || tick) ? '0 : cnt_q + 1'b1;
    end

endmodule

// File: rtl/safecrack_param_fsm.sv
// safecrack_param_fsm: parametrised combination lock with code reprogramming and timed lockout (optional AUTO_RELOCK_EN)
module safecrack_param_fsm
    import safecrack_pkg::*;
#(
    parameter int NBTN          = 4,
    parameter int CODE_LEN      = 3,
    parameter int MAX_ERR       = 3,
    parameter int LOCK_SECS     = 10,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter logic [CODE_LEN*NBTN-1:0] DEFAULT_CODE = {4'b0100, 4'b0010, 4'b0001}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ms,
    input  logic [NBTN-1:0]      btn,
    output logic                 unlocked,
    output logic                 locked_out,
    output logic [MAX_ERR-1:0]   leds_erros,
    output logic [CODE_LEN-1:0]  leds_digitos,
    output logic [LOCK_SECS-1:0] leds_segundos
);

    localparam int DW = $clog2(CODE_LEN + 1);
    localparam int EW = $clog2(MAX_ERR + 1);
    localparam int SW = $clog2(LOCK_SECS + 1);
    localparam logic [DW-1:0] D_LAST = DW'(CODE_LEN - 1);
    localparam logic [EW-1:0] E_MAX  = EW'(MAX_ERR);
    localparam logic [SW-1:0] S_MAX  = SW'(LOCK_SECS);

    state_t                     state_q;
    logic [CODE_LEN*NBTN-1:0]   code_q, new_q, new_d;
    logic [NBTN-1:0]            btn_q, ref_sym;
    logic [DW-1:0]              digit_q;
    logic [EW-1:0]              err_q, err_inc;
    logic [SW-1:0]              sec_q, sec_inc;
    logic                       mis_q, miss_d, press, last, tick, tmr_en;

    assign press   = (|btn) && !(|btn_q);
    assign last    = digit_q == D_LAST;
    assign miss_d  = mis_q || (btn != ref_sym);
    assign err_inc = err_q + 1'b1;
    assign sec_inc = sec_q + 1'b1;

`ifdef AUTO_RELOCK_EN
    assign tmr_en = (state_q == LOCK) || (state_q == OPEN && !ms);
`else
    assign tmr_en = state_q == LOCK;
`endif

    sec_tick_gen #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tmr_en),
        .tick (tick)
    );

    // Select the stored digit under test and build the code being programmed
    always_comb begin
        ref_sym = '0;
        new_d   = new_q;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (digit_q == DW'(i)) begin
                ref_sym = code_q[i*NBTN +: NBTN];
                new_d[i*NBTN +: NBTN] = btn;
            end
        end
    end

    // Lock state machine: code entry judged only after the last digit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ENTER;
            code_q  <= DEFAULT_CODE;
            new_q   <= '0;
            btn_q   <= '0;
            digit_q <= '0;
            err_q   <= '0;
            sec_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            btn_q <= btn;
            case (state_q)
                ENTER: if (press) begin
                    if (last) begin
                        digit_q <= '0;
                        mis_q   <= 1'b0;
                        if (!miss_d) begin
                            state_q <= OPEN;
                            err_q   <= '0;
                        end else begin
                            err_q <= err_inc;
                            if (err_inc == E_MAX) state_q <= LOCK;
                        end
                    end else begin
                        digit_q <= digit_q + 1'b1;
                        mis_q   <= miss_d;
                    end
                end
                OPEN: begin
                    if (ms) begin
                        state_q <= PROG;
                        digit_q <= '0;
                        sec_q   <= '0;
                    end else if (press) begin
                        state_q <= ENTER;
                        sec_q   <= '0;
                    end
`ifdef AUTO_RELOCK_EN
                    else if (tick) begin
                        if (sec_inc == S_MAX) begin
                            state_q <= ENTER;
                            sec_q   <= '0;
                        end else begin
                            sec_q <= sec_inc;
                        end
                    end
`endif
                end
                PROG: begin
                    if (!ms) begin
                        state_q <= OPEN;
                        digit_q <= '0;
                    end else if (press) begin
                        new_q <= new_d;
                        if (last) begin
                            code_q  <= new_d;
                            state_q <= ENTER;
                            digit_q <= '0;
                        end else begin
                            digit_q <= digit_q + 1'b1;
                        end
                    end
                end
                LOCK: if (tick) begin
                    if (sec_inc == S_MAX) begin
                        state_q <= ENTER;
                        err_q   <= '0;
                        sec_q   <= '0;
                    end else begin
                        sec_q <= sec_inc;
                    end
                end
                default: state_q <= ENTER;
            endcase
        end
    end

    assign unlocked      = state_q == OPEN;
    assign locked_out    = state_q == LOCK;
    assign leds_erros    = MAX_ERR'(thermo(int'(err_q), MAX_ERR));
    assign leds_digitos  = (state_q == ENTER || state_q == PROG) ? CODE_LEN'(thermo(int'(digit_q), CODE_LEN)) : '0;
    assign leds_segundos = LOCK_SECS'(thermo(int'(sec_q), LOCK_SECS));

endmodule

// File: tb/tb_safecrack_param_fsm.sv
// tb_safecrack_param_fsm: scoreboard bench with a sequence-level reference model of the lock
module tb_safecrack_param_fsm;

    localparam int NBTN = 4, CL = 3, ME = 3, LS = 10, TPS = 4;
    localparam logic [CL*NBTN-1:0] DC = {4'b0100, 4'b0010, 4'b0001};
    localparam int S_ENTER = 0, S_OPEN = 1, S_PROG = 2, S_LOCK = 3;

    logic clk = 1'b0;
    logic rst = 1'b1, ms = 1'b0;
    logic [NBTN-1:0] btn = '0;
    logic unlocked, locked_out;
    logic [ME-1:0] leds_erros;
    logic [CL-1:0] leds_digitos;
    logic [LS-1:0] leds_segundos;

    always #5 clk = ~clk;

    safecrack_param_fsm #(
        .NBTN(NBTN), .CODE_LEN(CL), .MAX_ERR(ME), .LOCK_SECS(LS),
        .TICKS_PER_SEC(TPS), .DEFAULT_CODE(DC)
    ) dut (
        .clk(clk), .rst(rst), .ms(ms), .btn(btn),
        .unlocked(unlocked), .locked_out(locked_out),
        .leds_erros(leds_erros), .leds_digitos(leds_digitos), .leds_segundos(leds_segundos)
    );

    typedef struct packed {
        logic          u;
        logic          l;
        logic [ME-1:0] e;
        logic [CL-1:0] d;
        logic [LS-1:0] s;
    } exp_t;

    exp_t q[$];
    int n_checks = 0, n_fail = 0;

    int st, err, lcyc;
    logic [NBTN-1:0] code[CL];
    logic [NBTN-1:0] entered[$], newc[$];
    logic [NBTN-1:0] prev;
    logic cm;

    function automatic logic [31:0] th(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        logic [CL*NBTN-1:0] dcv;
        dcv = DC;
        st = S_ENTER;
        for (int i = 0; i < CL; i++) code[i] = dcv[i*NBTN +: NBTN];
        entered.delete();
        newc.delete();
        err = 0;
        lcyc = 0;
        prev = '0;
    endtask

    // One clock: drive inputs, advance the reference model, queue the expected outputs
    task automatic step(input logic r, input logic m, input logic [NBTN-1:0] b);
        bit pr, ok;
        exp_t e;
        @(negedge clk);
        rst = r; ms = m; btn = b;
        if (r) model_reset();
        else begin
            pr = (b != 0) && (prev == 0);
            case (st)
                S_ENTER: if (pr) begin
                    entered.push_back(b);
                    if (entered.size() == CL) begin
                        ok = 1;
                        for (int i = 0; i < CL; i++) if (entered[i] != code[i]) ok = 0;
                        entered.delete();
                        if (ok) begin st = S_OPEN; err = 0; end
                        else begin
                            err++;
                            if (err == ME) begin st = S_LOCK; lcyc = 0; end
                        end
                    end
                end
                S_OPEN: if (m) begin st = S_PROG; newc.delete(); end
                        else if (pr) st = S_ENTER;
                S_PROG: if (!m) st = S_OPEN;
                        else if (pr) begin
                            newc.push_back(b);
                            if (newc.size() == CL) begin
                                for (int i = 0; i < CL; i++) code[i] = newc[i];
                                st = S_ENTER;
                            end
                        end
                default: begin
                    lcyc++;
                    if (lcyc == LS * TPS) begin st = S_ENTER; err = 0; end
                end
            endcase
            prev = b;
        end
        e.u = st == S_OPEN;
        e.l = st == S_LOCK;
        e.e = ME'(th(err));
        e.d = st == S_ENTER ? CL'(th(entered.size())) : st == S_PROG ? CL'(th(newc.size())) : '0;
        e.s = st == S_LOCK ? LS'(th(lcyc / TPS)) : '0;
        q.push_back(e);
    endtask

    task automatic press(input logic [NBTN-1:0] s);
        step(1'b0, cm, s);
        step(1'b0, cm, '0);
    endtask

    task automatic enter3(input logic [NBTN-1:0] a, input logic [NBTN-1:0] b, input logic [NBTN-1:0] c);
        press(a); press(b); press(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, cm, '0);
    endtask

    // Monitor: compare every output against the queued expectation just after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("unlocked", int'(unlocked), int'(e.u));
                chk("locked_out", int'(locked_out), int'(e.l));
                chk("leds_erros", int'(leds_erros), int'(e.e));
                chk("leds_digitos", int'(leds_digitos), int'(e.d));
                chk("leds_segundos", int'(leds_segundos), int'(e.s));
            end
        end
    end

    initial begin
        logic [NBTN-1:0] sym, bv;
        cm = 1'b0;
        model_reset();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        idle(2);
        enter3(4'b0001, 4'b0010, 4'b0100);
        idle(2);
        press(4'b1000);
        enter3(4'b0001, 4'b1000, 4'b0100);
        idle(2);
        enter3(4'b0001, 4'b1000, 4'b0100);
        enter3(4'b1111, 4'b0010, 4'b0100);
        press(4'b0001);
        press(4'b0010);
        idle(45);
        enter3(4'b0001, 4'b0010, 4'b0100);
        cm = 1'b1; idle(1);
        enter3(4'b1000, 4'b1000, 4'b0001);
        cm = 1'b0; idle(1);
        enter3(4'b0001, 4'b0010, 4'b0100);
        enter3(4'b1000, 4'b1000, 4'b0001);
        cm = 1'b1; idle(1);
        press(4'b0010);
        cm = 1'b0; idle(1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'b0010);
        idle(1);
        enter3(4'b1000, 4'b1000, 4'b0001);
        press(4'b0001);
        for (int k = 0; k < 3; k++) enter3(4'b0100, 4'b0100, 4'b0100);
        idle(13);
        step(1'b1, 1'b0, '0);
        idle(1);
        enter3(4'b0001, 4'b0010, 4'b0100);
        cm = 1'b1; idle(1);
        press(4'b1000);
        step(1'b1, 1'b1, '0);
        cm = 1'b0; idle(1);
        enter3(4'b0001, 4'b0010, 4'b0100);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) cm = ~cm;
            sym = (st == S_ENTER && $urandom_range(0, 2) != 0) ? code[entered.size()] : NBTN'($urandom_range(1, 15));
            bv = $urandom_range(0, 1) != 0 ? '0 : sym;
            step($urandom_range(0, 599) == 0, cm, bv);
        end
        idle(3);
        repeat (2) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
